// File: rtl/wr_burst_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wr_burst_accum_pkg
// Brief    : Shared types and sizing helpers for the write-burst accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package wr_burst_accum_pkg;

    localparam int unsigned c_BEAT_LEN_W = 9;

    typedef logic [c_BEAT_LEN_W-1:0] beat_len_t;

    // Enough headroom for every queued AW carrying a full 256-beat burst.
    function automatic int unsigned rem_cnt_width(input int unsigned max_txns);
        return c_BEAT_LEN_W + $clog2(max_txns + 1);
    endfunction

    function automatic int unsigned accu_cnt_width(input int unsigned max_txns,
                                                   input int unsigned presc_div);
        return rem_cnt_width(max_txns) - $clog2(presc_div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wr_len_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wr_len_fifo
// Brief    : Bypass-free FIFO of per-AW beat counts with synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module wr_len_fifo
    import wr_burst_accum_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      i_flush,
    input  logic      i_push,
    input  beat_len_t i_data,
    input  logic      i_pop,
    output beat_len_t o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int unsigned c_PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned c_CNT_W = $clog2(Depth + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(Depth - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(Depth);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    beat_len_t          r_mem [Depth];
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/wr_burst_accum.sv
`default_nettype none
// ============================================================================
// Module   : wr_burst_accum
// Brief    : Tracks outstanding AXI W beats over queued AWs, prescaled output.
//            Define WR_BURST_ACCUM_ERR_EN to add sticky protocol error flags.
// Revision : 1.0 - initial release
// ============================================================================
module wr_burst_accum
    import wr_burst_accum_pkg::*;
#(
    parameter int unsigned MaxWrTxns    = 4,
    parameter int unsigned PrescalerDiv = 1,
    parameter type         accu_cnt_t   = logic
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       aw_hs_i,
    input  logic [7:0] aw_len_i,
    input  logic       w_hs_i,
    input  logic       w_last_i,
    output accu_cnt_t  accum_burst_length_o,
    output logic       full_o,
    output logic       empty_o
`ifdef WR_BURST_ACCUM_ERR_EN
    ,
    output logic       err_early_last_o,
    output logic       err_missing_last_o,
    output logic       err_orphan_w_o,
    output logic       err_aw_overflow_o
`endif
);

    localparam int unsigned c_REM_W    = rem_cnt_width(MaxWrTxns);
    localparam int unsigned c_PRESC_SH = $clog2(PrescalerDiv);

    typedef logic [c_REM_W-1:0] rem_cnt_t;

    beat_len_t w_aw_len;
    beat_len_t w_fifo_head;
    beat_len_t w_head_len;
    beat_len_t w_beat_nxt;
    beat_len_t r_beat_cnt;
    rem_cnt_t  r_remaining;
    rem_cnt_t  w_rem_add;
    rem_cnt_t  w_rem_sub;
    logic      w_fifo_full;
    logic      w_fifo_empty;
    logic      w_aw_ok;
    logic      w_head_vld;
    logic      w_w_act;
    logic      w_exhausted;
    logic      w_done;
    logic      w_push;
    logic      w_pop;

    wr_len_fifo #(
        .Depth (MaxWrTxns)
    ) u_len_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_flush (flush_i),
        .i_push  (w_push),
        .i_data  (w_aw_len),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // With an empty queue the incoming AW acts as the head for this cycle's W.
    always_comb begin
        w_aw_len    = {1'b0, aw_len_i} + 9'd1;
        w_aw_ok     = aw_hs_i & ~w_fifo_full;
        w_head_vld  = ~w_fifo_empty | w_aw_ok;
        w_head_len  = w_fifo_empty ? w_aw_len : w_fifo_head;
        w_w_act     = w_hs_i & w_head_vld;
        w_beat_nxt  = r_beat_cnt + 9'd1;
        w_exhausted = (w_beat_nxt == w_head_len);
        w_done      = w_w_act & (w_last_i | w_exhausted);
        w_push      = w_aw_ok & ~(w_fifo_empty & w_done);
        w_pop       = w_done & ~w_fifo_empty;
        w_rem_add   = w_aw_ok ? rem_cnt_t'(w_aw_len) : '0;
        w_rem_sub   = '0;
        if (w_done)       w_rem_sub = rem_cnt_t'(w_head_len - r_beat_cnt);
        else if (w_w_act) w_rem_sub = rem_cnt_t'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beat_cnt  <= '0;
            r_remaining <= '0;
        end else if (flush_i) begin
            r_beat_cnt  <= '0;
            r_remaining <= '0;
        end else begin
            if (w_done)       r_beat_cnt <= '0;
            else if (w_w_act) r_beat_cnt <= w_beat_nxt;
            r_remaining <= r_remaining + w_rem_add - w_rem_sub;
        end
    end

    assign accum_burst_length_o = accu_cnt_t'(r_remaining >> c_PRESC_SH);
    assign full_o               = w_fifo_full;
    assign empty_o              = w_fifo_empty;

`ifdef WR_BURST_ACCUM_ERR_EN
    logic r_err_early_last;
    logic r_err_missing_last;
    logic r_err_orphan_w;
    logic r_err_aw_overflow;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_early_last   <= 1'b0;
            r_err_missing_last <= 1'b0;
            r_err_orphan_w     <= 1'b0;
            r_err_aw_overflow  <= 1'b0;
        end else if (flush_i) begin
            r_err_early_last   <= 1'b0;
            r_err_missing_last <= 1'b0;
            r_err_orphan_w     <= 1'b0;
            r_err_aw_overflow  <= 1'b0;
        end else begin
            if (w_done & w_last_i & ~w_exhausted)    r_err_early_last   <= 1'b1;
            if (w_w_act & ~w_last_i & w_exhausted)   r_err_missing_last <= 1'b1;
            if (w_hs_i & ~w_head_vld)                r_err_orphan_w     <= 1'b1;
            if (aw_hs_i & w_fifo_full)               r_err_aw_overflow  <= 1'b1;
        end
    end

    assign err_early_last_o   = r_err_early_last;
    assign err_missing_last_o = r_err_missing_last;
    assign err_orphan_w_o     = r_err_orphan_w;
    assign err_aw_overflow_o  = r_err_aw_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wr_burst_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_wr_burst_accum
// Brief    : Directed self-checking bench; three DUT variants share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wr_burst_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        aw_hs;
    logic [7:0]  aw_len;
    logic        w_hs;
    logic        w_last;
    logic [15:0] acc_a, acc_b, acc_c;
    logic        full_a, full_b, full_c;
    logic        empty_a, empty_b, empty_c;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

`ifdef WR_BURST_ACCUM_ERR_EN
    // {early_last, missing_last, orphan_w, aw_overflow}
    logic [3:0] err_a, err_b, err_c;
`endif

    wr_burst_accum #(.MaxWrTxns(4), .PrescalerDiv(1), .accu_cnt_t(logic [15:0])) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .aw_hs_i(aw_hs), .aw_len_i(aw_len),
        .w_hs_i(w_hs), .w_last_i(w_last), .accum_burst_length_o(acc_a),
        .full_o(full_a), .empty_o(empty_a)
`ifdef WR_BURST_ACCUM_ERR_EN
        , .err_early_last_o(err_a[3]), .err_missing_last_o(err_a[2]),
        .err_orphan_w_o(err_a[1]), .err_aw_overflow_o(err_a[0])
`endif
    );

    wr_burst_accum #(.MaxWrTxns(4), .PrescalerDiv(4), .accu_cnt_t(logic [15:0])) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .aw_hs_i(aw_hs), .aw_len_i(aw_len),
        .w_hs_i(w_hs), .w_last_i(w_last), .accum_burst_length_o(acc_b),
        .full_o(full_b), .empty_o(empty_b)
`ifdef WR_BURST_ACCUM_ERR_EN
        , .err_early_last_o(err_b[3]), .err_missing_last_o(err_b[2]),
        .err_orphan_w_o(err_b[1]), .err_aw_overflow_o(err_b[0])
`endif
    );

    wr_burst_accum #(.MaxWrTxns(2), .PrescalerDiv(1), .accu_cnt_t(logic [15:0])) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .aw_hs_i(aw_hs), .aw_len_i(aw_len),
        .w_hs_i(w_hs), .w_last_i(w_last), .accum_burst_length_o(acc_c),
        .full_o(full_c), .empty_o(empty_c)
`ifdef WR_BURST_ACCUM_ERR_EN
        , .err_early_last_o(err_c[3]), .err_missing_last_o(err_c[2]),
        .err_orphan_w_o(err_c[1]), .err_aw_overflow_o(err_c[0])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic aw, input logic [7:0] len, input logic w,
                       input logic last, input logic fl);
        aw_hs  = aw;
        aw_len = len;
        w_hs   = w;
        w_last = last;
        flush  = fl;
        @(posedge clk);
        #1;
        aw_hs  = 1'b0;
        aw_len = 8'd0;
        w_hs   = 1'b0;
        w_last = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        aw_hs  = 1'b0;
        aw_len = 8'd0;
        w_hs   = 1'b0;
        w_last = 1'b0;
        #2;
        chk("rst_acc", acc_a, 0);
        chk("rst_full", full_a, 0);
        chk("rst_empty", empty_a, 1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single burst of 4 beats, last on the 4th
        cyc(1, 8'd3, 0, 0, 0);
        chk("s1_aw_acc", acc_a, 4);
        chk("s1_aw_empty", empty_a, 0);
        cyc(0, 0, 1, 0, 0);
        chk("s1_b1", acc_a, 3);
        cyc(0, 0, 1, 0, 0);
        chk("s1_b2", acc_a, 2);
        cyc(0, 0, 1, 0, 0);
        chk("s1_b3", acc_a, 1);
        cyc(0, 0, 1, 1, 0);
        chk("s1_b4", acc_a, 0);
        chk("s1_empty", empty_a, 1);
`ifdef WR_BURST_ACCUM_ERR_EN
        chk("s1_err", err_a, 4'b0000);
`endif
        cyc(0, 0, 0, 0, 1);

        // Prescaler: 8 + 4 beats queued, divide by 4
        cyc(1, 8'd7, 0, 0, 0);
        cyc(1, 8'd3, 0, 0, 0);
        chk("s2_acc_b", acc_b, 3);
        chk("s2_acc_a", acc_a, 12);
        cyc(0, 0, 1, 0, 0);
        chk("s2_b1_acc_b", acc_b, 2);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        chk("s2_b5_acc_b", acc_b, 1);
        chk("s2_b5_acc_a", acc_a, 7);
        cyc(0, 0, 0, 0, 1);

        // Queue depth 2 overflow
        cyc(1, 8'd0, 0, 0, 0);
        chk("s3_aw1_acc", acc_c, 1);
        chk("s3_aw1_full", full_c, 0);
        cyc(1, 8'd0, 0, 0, 0);
        chk("s3_aw2_acc", acc_c, 2);
        chk("s3_aw2_full", full_c, 1);
        cyc(1, 8'd0, 0, 0, 0);
        chk("s3_aw3_acc", acc_c, 2);
        chk("s3_aw3_full", full_c, 1);
        chk("s3_acc_a", acc_a, 3);
`ifdef WR_BURST_ACCUM_ERR_EN
        chk("s3_ovf", err_c[0], 1);
`endif
        cyc(0, 0, 0, 0, 1);
        chk("s3_flush_acc", acc_c, 0);
        chk("s3_flush_full", full_c, 0);

        // Bypass on empty queue, single-beat burst
        cyc(1, 8'd0, 1, 1, 0);
        chk("s4_byp_acc", acc_a, 0);
        chk("s4_byp_empty", empty_a, 1);
`ifdef WR_BURST_ACCUM_ERR_EN
        chk("s4_byp_err", err_a, 4'b0000);
`endif
        // Bypass with a continuing burst, then AW+W on a non-empty queue
        cyc(1, 8'd2, 1, 0, 0);
        chk("s4_byp2_acc", acc_a, 2);
        chk("s4_byp2_empty", empty_a, 0);
        cyc(1, 8'd3, 1, 0, 0);
        chk("s4_net_acc", acc_a, 5);
        cyc(0, 0, 1, 0, 0);
        chk("s4_exh_acc", acc_a, 4);
        chk("s4_exh_empty", empty_a, 0);
`ifdef WR_BURST_ACCUM_ERR_EN
        chk("s4_missing", err_a[2], 1);
`endif
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("s4_end_acc", acc_a, 0);
        chk("s4_end_empty", empty_a, 1);
        cyc(0, 0, 0, 0, 1);

        // Early w_last on beat 3 of 8
        cyc(1, 8'd7, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("s5_mid_acc", acc_a, 6);
        cyc(0, 0, 1, 1, 0);
        chk("s5_acc", acc_a, 0);
        chk("s5_empty", empty_a, 1);
`ifdef WR_BURST_ACCUM_ERR_EN
        chk("s5_early", err_a[3], 1);
`endif
        cyc(0, 0, 0, 0, 1);

        // Orphan W beat is ignored
        cyc(0, 0, 1, 1, 0);
        chk("s6_orphan_acc", acc_a, 0);
        chk("s6_orphan_empty", empty_a, 1);
`ifdef WR_BURST_ACCUM_ERR_EN
        chk("s6_orphan_flag", err_a[1], 1);
`endif
        cyc(0, 0, 0, 0, 1);

        // Flush beats same-cycle AW and W
        cyc(1, 8'd1, 0, 0, 0);
        cyc(1, 8'd1, 0, 0, 0);
        cyc(1, 8'd1, 0, 0, 0);
        chk("s7_acc_a", acc_a, 6);
        chk("s7_acc_c", acc_c, 4);
        cyc(1, 8'd5, 1, 1, 1);
        chk("s7_fl_acc_a", acc_a, 0);
        chk("s7_fl_empty_a", empty_a, 1);
        chk("s7_fl_acc_c", acc_c, 0);
        chk("s7_fl_full_c", full_c, 0);
`ifdef WR_BURST_ACCUM_ERR_EN
        chk("s7_fl_err_a", err_a, 4'b0000);
        chk("s7_fl_err_c", err_c, 4'b0000);
`endif

        // Asynchronous reset mid-operation
        cyc(1, 8'd3, 0, 0, 0);
        chk("s8_pre_acc", acc_a, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s8_rst_acc", acc_a, 0);
        chk("s8_rst_empty", empty_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
